dram_arbiter: RTL and testbench
===============================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 The block SHALL have one clock `clk`; reset `rst` SHALL be asynchronous and active-high.
REQ-002 Port `clk`, input, 1: rising-edge clock shared with data_ram.
REQ-003 Port `rst`, input, 1: asynchronous, active-high reset.
REQ-004 Ports `m0_req`/`m1_req`, input, 1: access request from master 0 (CPU MEM stage) / master 1 (loader/DMA).
REQ-005 Ports `m0_we`/`m1_we`, input, 1: 1 = write, 0 = read.
REQ-006 Ports `m0_addr`/`m1_addr`, input, `DataAddrBus`: byte address.
REQ-007 Ports `m0_sel`/`m1_sel`, input, 4: byte lane enables.
REQ-008 Ports `m0_wdata`/`m1_wdata`, input, `DataBus`: write data.
REQ-009 Ports `m0_ack`/`m1_ack`, output, 1: one-cycle completion pulse.
REQ-010 Port `rdata_o`, output, `DataBus`: registered read data, valid while the corresponding ack is high.
REQ-011 Port `stall_o`, output, 1: CPU stall request, equal to m0_req & ~m0_ack.
REQ-012 Ports `ram_ce`, `ram_we`, `ram_re`, output, 1 each: data_ram controls.
REQ-013 Ports `ram_addr`, `ram_sel`, `ram_wdata`, output, `DataAddrBus`/4/`DataBus`: data_ram address, lanes and write data.
REQ-014 Port `ram_rdata`, input, `DataBus`: data_ram combinational read data.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-016 IDLE: if any req=1 at a rising edge, arbitrate, latch the winner's we/addr/sel/wdata and the grant id, and go to ACCESS; otherwise stay in IDLE.
REQ-017 Arbitration SHALL be round-robin over two masters using register `last_gnt`: on a tie the master not granted last wins; a single requester always wins.
REQ-018 ACCESS: drive ram_ce=`ChipEnable` and ram_addr/sel/wdata from the latch; set ram_we=`WriteEnable`, ram_re=0 for a write; set ram_re=`ReadEnable`, ram_we=0 for a read. Go to RESP at the next edge.
REQ-019 At the ACCESS->RESP edge: a read SHALL capture ram_rdata into rdata_o; a write SHALL leave rdata_o unchanged. The write commits in data_ram at this edge.
REQ-020 RESP: assert the granted master's ack for exactly one cycle; update last_gnt to the granted id.
REQ-021 Arbitration in RESP SHALL work as in IDLE and SHALL use the updated last_gnt. A req still high from the acked master counts as a new request. Go to ACCESS if any req=1, otherwise go to IDLE.
REQ-022 Latency SHALL be: req sampled at edge N, RAM driven in cycle N+1, ack in cycle N+2. Peak throughput SHALL be one access per 2 cycles.
REQ-023 Masters SHALL hold req/we/addr/sel/wdata stable until ack. A master SHALL present new request fields in its ack cycle if it keeps req high. Changes in the inputs during ACCESS SHALL have no effect.
REQ-024 Outside ACCESS: ram_ce SHALL be `ChipDisable`, ram_we and ram_re SHALL be 0, and ram_addr/sel/wdata SHALL be 0.
REQ-025 m0_ack and m1_ack SHALL never be high in the same cycle.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, last_gnt=1 (so master 0 wins the first tie), rdata_o=`ZeroWord`, both acks 0, and the latch to 0.
REQ-027 rst=1 during ACCESS SHALL drop ram_ce and ram_we combinationally, so no RAM write commits at the following edge; the aborted access is never acked.

Structure
REQ-028 State encodings and the ChipEnable/ChipDisable/WriteEnable/ReadEnable/ZeroWord constants SHALL come from the shared defines.v; no local literals.
REQ-029 The round-robin decision (two reqs plus last_gnt in, grant id out) SHALL be a combinational sub-module named rr_arb2.
REQ-030 The block SHALL sit between the MEM stage, the loader and data_ram, with ram_* wired one-to-one to data_ram.

Verification
REQ-031 Single write then read: m0 writes 0xDEADBEEF to 0x10 with sel=0xF, then reads 0x10 -> m0_ack in cycle N+2 each time, then rdata_o=0xDEADBEEF.
REQ-032 Byte lanes: write 0x11223344 to 0x20, then m1 writes 0xAAxxxxxx to 0x20 with sel=0x8, then read -> 0xAA223344.
REQ-033 Contention: m0_req=m1_req=1 held from reset -> acks alternate m0, m1, m0, m1 every 2 cycles; stall_o=1 except in m0 ack cycles.
REQ-034 Back-to-back: m1 keeps req high through its ack while m0 is idle -> consecutive m1 acks 2 cycles apart, with no IDLE visit.
REQ-035 Reset mid-access: m0 writes 0x55 to 0x30 and rst is asserted in ACCESS -> no ack, a later read of 0x30 returns the old value, ram_ce=0 while rst=1.
REQ-036 Idle: no requests -> ram_ce=`ChipDisable` and the acks stay 0 for 20 cycles.

Source files
------------

// File: rtl/dram_arbiter_pkg.sv
// Shared definitions for the DRAM arbiter slice: bus widths, data_ram control
// levels, the reset data word and the FSM state encoding.
package dram_arbiter_pkg;
  localparam int DataAddrBus = 32;
  localparam int DataBus     = 32;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;

  localparam logic [DataBus-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;
endpackage

// File: rtl/dram_arbiter_if.sv
// Master-side bus of the DRAM arbiter: two request ports (CPU MEM stage = m0,
// loader/DMA = m1), their one-cycle acks, the shared read data and the CPU stall.
//
// Handshake: a master raises mN_req with we/addr/sel/wdata and holds all of them
// stable until mN_ack. mN_ack is a single-cycle pulse; rdata_o is valid while
// the ack of a read is high. Keeping req high in the ack cycle starts a new
// request whose fields must already be presented in that cycle.
interface dram_arbiter_if;
  import dram_arbiter_pkg::*;

  logic                   m0_req;
  logic                   m0_we;
  logic [DataAddrBus-1:0] m0_addr;
  logic [3:0]             m0_sel;
  logic [DataBus-1:0]     m0_wdata;
  logic                   m0_ack;

  logic                   m1_req;
  logic                   m1_we;
  logic [DataAddrBus-1:0] m1_addr;
  logic [3:0]             m1_sel;
  logic [DataBus-1:0]     m1_wdata;
  logic                   m1_ack;

  logic [DataBus-1:0]     rdata_o;
  logic                   stall_o;

  modport master (
    output m0_req, m0_we, m0_addr, m0_sel, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_sel, m1_wdata,
    input  m0_ack, m1_ack, rdata_o, stall_o
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_sel, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_sel, m1_wdata,
    output m0_ack, m1_ack, rdata_o, stall_o
  );
endinterface

// File: rtl/dram_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin decision.
//   req0_i/req1_i : requests
//   last_gnt_i    : id of the master granted last
//   gnt_o         : winning id (meaningful only when valid_o=1)
//   valid_o       : at least one request present
// A lone requester always wins; on a tie the master not granted last wins.
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_gnt_i,
  output logic gnt_o,
  output logic valid_o
);
  assign valid_o = req0_i | req1_i;
  assign gnt_o   = (req0_i & req1_i) ? ~last_gnt_i : req1_i;
endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one data_ram between the CPU MEM stage (m0) and the
// loader/DMA (m1). Each access takes IDLE/RESP -> ACCESS -> RESP.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : master request/ack bus, rdata_o, stall_o
//   ram_*           : data_ram controls, address, lanes, write/read data
//   state_dbg_o     : current FSM state for observation
module dram_arbiter
  import dram_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  dram_arbiter_if.slave          bus,
  output logic                   ram_ce,
  output logic                   ram_we,
  output logic                   ram_re,
  output logic [DataAddrBus-1:0] ram_addr,
  output logic [3:0]             ram_sel,
  output logic [DataBus-1:0]     ram_wdata,
  input  logic [DataBus-1:0]     ram_rdata,
  output state_e                 state_dbg_o
);
  state_e                 state_q, state_d;
  logic                   gnt_q, gnt_d;
  logic                   last_gnt_q, last_gnt_d;
  logic                   we_q, we_d;
  logic [DataAddrBus-1:0] addr_q, addr_d;
  logic [3:0]             sel_q, sel_d;
  logic [DataBus-1:0]     wdata_q, wdata_d;
  logic [DataBus-1:0]     rdata_q, rdata_d;

  logic arb_last, arb_gnt, arb_valid;

  // In RESP the grant being acked already counts as "last", so back-to-back
  // arbitration sees the updated history without waiting a cycle.
  assign arb_last = (state_q == RESP) ? gnt_q : last_gnt_q;

  rr_arb2 u_rr_arb2 (
    .req0_i     (bus.m0_req),
    .req1_i     (bus.m1_req),
    .last_gnt_i (arb_last),
    .gnt_o      (arb_gnt),
    .valid_o    (arb_valid)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;

    case (state_q)
      IDLE, RESP: begin
        if (state_q == RESP) last_gnt_d = gnt_q;
        if (arb_valid) begin
          state_d = ACCESS;
          gnt_d   = arb_gnt;
          we_d    = arb_gnt ? bus.m1_we    : bus.m0_we;
          addr_d  = arb_gnt ? bus.m1_addr  : bus.m0_addr;
          sel_d   = arb_gnt ? bus.m1_sel   : bus.m0_sel;
          wdata_d = arb_gnt ? bus.m1_wdata : bus.m0_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!we_q) rdata_d = ram_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= ZeroWord;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // RAM drive is gated by rst directly so an access aborted by reset cannot
  // commit at the next edge, independent of reset propagation into state_q.
  always_comb begin
    ram_ce    = ChipDisable;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    ram_sel   = '0;
    ram_wdata = '0;
    if (state_q == ACCESS && !rst) begin
      ram_ce    = ChipEnable;
      ram_addr  = addr_q;
      ram_sel   = sel_q;
      ram_wdata = wdata_q;
      if (we_q) ram_we = WriteEnable;
      else      ram_re = ReadEnable;
    end
  end

  assign bus.m0_ack  = (state_q == RESP) && !gnt_q;
  assign bus.m1_ack  = (state_q == RESP) &&  gnt_q;
  assign bus.rdata_o = rdata_q;
  assign bus.stall_o = bus.m0_req & ~bus.m0_ack;
  assign state_dbg_o = state_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: behavioural data_ram, scoreboard of expected acks
// (master id, read data) checked whenever an ack appears, and one task per
// scenario with cycle-exact inline checks.
module tb_dram_arbiter;
  import dram_arbiter_pkg::*;

  logic clk;
  logic rst;
  logic ram_ce, ram_we, ram_re;
  logic [DataAddrBus-1:0] ram_addr;
  logic [3:0] ram_sel;
  logic [DataBus-1:0] ram_wdata, ram_rdata;
  state_e state_dbg;

  int checks = 0;
  int failures = 0;

  // {is_read, master id, expected read data}
  logic [33:0] exp_q[$];
  logic [31:0] shadow [0:255];
  logic [31:0] mem [0:255];

  dram_arbiter_if bus ();

  dram_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .ram_ce      (ram_ce),
    .ram_we      (ram_we),
    .ram_re      (ram_re),
    .ram_addr    (ram_addr),
    .ram_sel     (ram_sel),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- data_ram model ----------------
  assign ram_rdata = mem[ram_addr[9:2]];
  always @(posedge clk) begin
    if (ram_ce == ChipEnable && ram_we == WriteEnable) begin
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    if (bus.m0_ack || bus.m1_ack) begin
      checks++;
      if (bus.m0_ack && bus.m1_ack) begin
        failures++;
        $display("FAIL dual_ack: m0_ack=%0b m1_ack=%0b required one-hot", bus.m0_ack, bus.m1_ack);
      end
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack: m0_ack=%0b m1_ack=%0b with no pending access", bus.m0_ack, bus.m1_ack);
      end else begin
        e = exp_q.pop_front();
        if (bus.m1_ack !== e[32]) begin
          failures++;
          $display("FAIL ack_id: got m1_ack=%0b required id=%0d", bus.m1_ack, e[32]);
        end
        if (e[33]) begin
          checks++;
          if (bus.rdata_o !== e[31:0]) begin
            failures++;
            $display("FAIL read_data: got %h required %h", bus.rdata_o, e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_master(input bit id, input bit req, input bit we,
                              input logic [31:0] addr, input logic [3:0] sel,
                              input logic [31:0] wd);
    if (!id) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_sel = sel; bus.m0_wdata = wd;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_sel = sel; bus.m1_wdata = wd;
    end
  endtask

  // Record the expected outcome of an access that will be acked.
  task automatic push_exp(input bit id, input bit we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wd);
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) shadow[addr[9:2]][8*b +: 8] = wd[8*b +: 8];
      exp_q.push_back({1'b0, id, 32'h0});
    end else begin
      exp_q.push_back({1'b1, id, shadow[addr[9:2]]});
    end
  endtask

  // One isolated access; called #1 after a rising edge with the bus idle.
  task automatic single(input bit id, input bit we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wd);
    logic ack;
    drive_master(id, 1'b1, we, addr, sel, wd);
    push_exp(id, we, addr, sel, wd);
    @(posedge clk); #1;
    ack = id ? bus.m1_ack : bus.m0_ack;
    checks++;
    if (ram_ce !== ChipEnable || ram_we !== we || ram_re !== !we || ram_addr !== addr || ack !== 1'b0) begin
      failures++;
      $display("FAIL access_cycle: ce=%0b we=%0b re=%0b addr=%h ack=%0b required ce=1 we=%0b re=%0b addr=%h ack=0",
               ram_ce, ram_we, ram_re, ram_addr, ack, we, !we, addr);
    end
    @(posedge clk); #1;
    ack = id ? bus.m1_ack : bus.m0_ack;
    checks++;
    if (ack !== 1'b1 || ram_ce !== ChipDisable) begin
      failures++;
      $display("FAIL ack_latency: ack=%0b ce=%0b required ack=1 ce=0 in cycle N+2", ack, ram_ce);
    end
    if (!id) begin
      checks++;
      if (bus.stall_o !== 1'b0) begin
        failures++;
        $display("FAIL stall_in_ack: stall_o=%0b required 0", bus.stall_o);
      end
    end
    drive_master(id, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_master(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive_master(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0 || bus.rdata_o !== ZeroWord ||
        ram_ce !== ChipDisable || state_dbg !== IDLE || bus.stall_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: acks=%0b%0b rdata=%h ce=%0b state=%0d stall=%0b required 00 0 0 IDLE 0",
               bus.m0_ack, bus.m1_ack, bus.rdata_o, ram_ce, state_dbg, bus.stall_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    single(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    single(1'b0, 1'b0, 32'h10, 4'hF, 32'h0);
    checks++;
    if (bus.rdata_o !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_read: rdata_o=%h required deadbeef", bus.rdata_o);
    end
  endtask

  task automatic test_byte_lanes();
    single(1'b0, 1'b1, 32'h20, 4'hF, 32'h11223344);
    single(1'b1, 1'b1, 32'h20, 4'h8, 32'hAA55AA55);
    single(1'b0, 1'b0, 32'h20, 4'hF, 32'h0);
    checks++;
    if (bus.rdata_o !== 32'hAA223344) begin
      failures++;
      $display("FAIL byte_lanes: rdata_o=%h required aa223344", bus.rdata_o);
    end
  endtask

  task automatic test_contention();
    bit exp0, exp1;
    rst = 1'b1;
    drive_master(1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    drive_master(1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
    for (int i = 0; i < 2; i++) begin
      push_exp(1'b0, 1'b0, 32'h10, 4'hF, 32'h0);
      push_exp(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      exp0 = (k % 4 == 2);
      exp1 = (k % 4 == 0);
      checks++;
      if (bus.m0_ack !== exp0 || bus.m1_ack !== exp1 || bus.stall_o !== !exp0) begin
        failures++;
        $display("FAIL contention_c%0d: m0_ack=%0b m1_ack=%0b stall=%0b required %0b %0b %0b",
                 k, bus.m0_ack, bus.m1_ack, bus.stall_o, exp0, exp1, !exp0);
      end
    end
    drive_master(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive_master(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bit exp1;
    drive_master(1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    for (int i = 0; i < 3; i++) push_exp(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      exp1 = (k % 2 == 0);
      checks++;
      if (bus.m1_ack !== exp1 || state_dbg === IDLE) begin
        failures++;
        $display("FAIL back_to_back_c%0d: m1_ack=%0b state=%0d required ack=%0b and no IDLE",
                 k, bus.m1_ack, state_dbg, exp1);
      end
    end
    drive_master(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_access();
    single(1'b0, 1'b1, 32'h30, 4'hF, 32'h12345678);
    drive_master(1'b0, 1'b1, 1'b1, 32'h30, 4'hF, 32'h00000055);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (ram_ce !== ChipDisable || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_ram_ctrl: ce=%0b we=%0b required 0 0", ram_ce, ram_we);
    end
    @(posedge clk); #1;
    drive_master(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.m0_ack !== 1'b0) begin
        failures++;
        $display("FAIL aborted_ack: m0_ack=%0b required 0", bus.m0_ack);
      end
    end
    single(1'b0, 1'b0, 32'h30, 4'hF, 32'h0);
    checks++;
    if (bus.rdata_o !== 32'h12345678) begin
      failures++;
      $display("FAIL reset_no_commit: rdata_o=%h required 12345678", bus.rdata_o);
    end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ram_ce !== ChipDisable || bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0) begin
        failures++;
        $display("FAIL idle_c%0d: ce=%0b acks=%0b%0b required 0 00", k, ram_ce, bus.m0_ack, bus.m1_ack);
      end
    end
  endtask

  task automatic test_random_singles();
    logic [31:0] addr;
    for (int i = 0; i < 10; i++) begin
      addr = {22'h0, 4'h4 + 4'($urandom_range(0, 3)), 6'h0};
      single(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr,
             4'($urandom_range(1, 15)), $urandom);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = 32'h0;
    test_reset();
    // Prime the lines used by the random test so every read has a defined value.
    for (int a = 4; a < 8; a++) single(1'b0, 1'b1, 32'(a * 64), 4'hF, 32'(a * 32'h01010101));
    test_write_read();
    test_byte_lanes();
    test_contention();
    test_back_to_back();
    test_reset_mid_access();
    test_idle();
    test_random_singles();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_acks: %0d accesses never acked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
